// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multicycle signed divider for the control unit's start/done
//            handshake. Produces the quotient on lo and the remainder on hi
//            (these feed the HI/LO input muxes).
//            Uses radix-2 restoring division on the operand magnitudes, one
//            quotient bit per clock, followed by a single sign-fix cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand/result width; iteration count equals WIDTH
// Ports
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low; clears all state
//   start        in   1      request, sampled only while idle
//   dividend     in   WIDTH  A operand (rs), two's complement
//   divisor      in   WIDTH  B operand (rt), two's complement
//   is_unsigned  in   1      (DIV_UNSIGNED_EN only) treat operands as unsigned
//   lo           out  WIDTH  quotient, registered
//   hi           out  WIDTH  remainder, registered
//   done         out  1      one-cycle completion pulse, registered
//   div_zero     out  1      divide-by-zero flag, held until next acceptance
//   busy         out  1      high whenever the divider is not idle
// Configuration
//   DIV_UNSIGNED_EN  when defined, adds is_unsigned (divu support)
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;   // quotient must be negated in FIX
  logic               dneg_q, dneg_d;   // dividend negative: remainder negated
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               use_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

`ifdef DIV_UNSIGNED_EN
  assign use_signed = ~is_unsigned;
`else
  assign use_signed = 1'b1;
`endif

  // Magnitudes are kept WIDTH bits unsigned, so negating the most negative
  // value yields 2^(WIDTH-1) exactly.
  assign a_mag = (use_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (use_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor and fits in WIDTH+1 bits; bit WIDTH of the difference
  // is therefore a clean borrow indicator.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    dneg_d     = dneg_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Complete on the accepting edge; hi/lo keep their old values.
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            quo_d      = a_mag;
            dvsr_d     = b_mag;
            rem_d      = '0;
            cnt_d      = '0;
            dneg_d     = use_signed & dividend[WIDTH-1];
            qneg_d     = use_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            div_zero_d = 1'b0;
            state_d    = S_ITER;
          end
        end
      end

      S_ITER: begin
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // remainder while the new quotient bit enters at the LSB.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = dneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      dneg_q     <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      dneg_q     <= dneg_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign lo       = lo_q;
  assign hi       = hi_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Self-checking bench for seq_divider: directed vector table,
//            multi-cycle corner sequences and randomized operations checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef DIV_UNSIGNED_EN
  logic         is_unsigned = 1'b0;
`endif
  logic [W-1:0] lo, hi;
  logic         done, div_zero, busy;

  int tests = 0;
  int fails = 0;

  // Reference model state: last completed (non-zero-divisor) result.
  logic [W-1:0] prev_lo = '0;
  logic [W-1:0] prev_hi = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    bit           dz;
  } vec_t;

  vec_t vecs[12];

  seq_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .lo          (lo),
    .hi          (hi),
    .done        (done),
    .div_zero    (div_zero),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: SV division truncates toward zero and the
  // remainder follows the dividend's sign, which is the required behaviour.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                                output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
    longint sa, sb, tq, tr;
    if (b == '0) begin
      dz = 1'b1;
      q  = prev_lo;
      r  = prev_hi;
    end else if (uns) begin
      dz = 1'b0;
      q  = a / b;
      r  = a % b;
    end else begin
      dz = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
    end
  endfunction

  // One full transaction: accept, scramble operands, wait (bounded) for done.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                       input logic [W-1:0] elo, input logic [W-1:0] ehi, input bit edz);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = uns;
`endif
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    if (edz) begin
      check({tag, " dz done"}, W'(done), W'(1));
      check({tag, " dz flag"}, W'(div_zero), W'(1));
      check({tag, " dz lo held"}, lo, elo);
      check({tag, " dz hi held"}, hi, ehi);
    end else begin
      check({tag, " div_zero cleared"}, W'(div_zero), W'(0));
      busy_cnt = busy ? 1 : 0;
      lat  = 0;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
        @(posedge clock);
        #1;
        if (done) begin
          seen = 1'b1;
          lat  = k;
        end else if (busy) begin
          busy_cnt++;
        end
      end
      check({tag, " latency"}, W'(lat), W'(W + 1));
      check({tag, " busy cycles"}, W'(busy_cnt), W'(W + 1));
      if (seen) begin
        check({tag, " lo"}, lo, elo);
        check({tag, " hi"}, hi, ehi);
        check({tag, " div_zero"}, W'(div_zero), W'(0));
        check({tag, " busy at done"}, W'(busy), W'(0));
      end
    end
    prev_lo = elo;
    prev_hi = ehi;
    @(posedge clock);
    #1;
    check({tag, " done one cycle"}, W'(done), W'(0));
  endtask

  initial begin
    logic [W-1:0] q, r;
    bit           dz;
    bit           uns;
    bit           seen;
    int           lat;
    int           done_cnt;
    logic [W-1:0] a, b;

    vecs[0]  = '{32'd100,      32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{32'd5,        32'd0,          32'hFFFFFFFD,   32'd1,          1'b1};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[5]  = '{32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[6]  = '{32'd0,        32'd5,          32'd0,          32'd0,          1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[8]  = '{32'd1,        32'h80000000,   32'd0,          32'd1,          1'b0};
    vecs[9]  = '{32'h80000000, 32'h80000000,   32'd1,          32'd0,          1'b0};
    vecs[10] = '{32'h7FFFFFFF, 32'hFFFFFFFF,   32'h80000001,   32'd0,          1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'd0,          32'h80000001,   32'd0,          1'b1};

    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset lo", lo, '0);
    check("reset hi", hi, '0);
    check("reset done", W'(done), W'(0));
    check("reset div_zero", W'(div_zero), W'(0));
    check("reset busy", W'(busy), W'(0));
    @(negedge clock);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].lo, vecs[i].hi, vecs[i].dz);
    end

`ifdef DIV_UNSIGNED_EN
    do_op("divu max/2", 32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0);
    do_op("div -1/2", 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0);
`endif

    // Start pulsed while busy is ignored
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
`ifdef DIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    @(posedge clock); #1; start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    dividend = 32'd9; divisor = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 6; k <= 45 && !seen; k++) begin
      @(posedge clock); #1;
      if (done) begin seen = 1'b1; lat = k; end
    end
    check("busy-start latency", W'(lat), W'(W + 1));
    check("busy-start lo", lo, 32'd333);
    check("busy-start hi", hi, 32'd1);
    prev_lo = 32'd333; prev_hi = 32'd1;
    @(posedge clock); #1;
    check("busy-start no second op", W'(busy), W'(0));

    // Reset in the middle of an operation aborts it without a done pulse
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort lo", lo, '0);
    check("abort hi", hi, '0);
    check("abort done", W'(done), W'(0));
    check("abort div_zero", W'(div_zero), W'(0));
    check("abort busy", W'(busy), W'(0));
    @(negedge clock);
    reset = 1'b1;
    prev_lo = '0; prev_hi = '0;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    check("abort no done", W'(done_cnt), W'(0));

    // Start held high across done begins a new op on the first idle cycle
    @(negedge clock);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("held first lo", lo, 32'd14);
    dividend = 32'd50; divisor = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    check("held re-accept busy", W'(busy), W'(1));
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clock); #1;
      if (done) begin seen = 1'b1; lat = k; end
    end
    check("held second latency", W'(lat), W'(W + 1));
    check("held second lo", lo, 32'd16);
    check("held second hi", hi, 32'd2);
    prev_lo = 32'd16; prev_hi = 32'd2;

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'h80000000;
        3: b = $urandom_range(1, 20);
        4: b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
`ifdef DIV_UNSIGNED_EN
      uns = 1'($urandom_range(0, 1));
`else
      uns = 1'b0;
`endif
      model(a, b, uns, q, r, dz);
      do_op($sformatf("rnd%0d", i), a, b, uns, q, r, dz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
